// File: rtl/smac_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// smac_ctrl_pkg : shared widths, counts and FSM encoding for the drain scheduler
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package smac_ctrl_pkg;

    localparam int N_REQ = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Accumulator result width: row-sum growth plus product and operand-count growth.
    function automatic int dw_calc(input int m, input int pa, input int pw, input int mno);
        return $clog2(m) + pa + pw + $clog2(mno) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb4.sv
// ----------------------------------------------------------------------------
// rr_arb4 : combinational 4-way round-robin arbiter, search starts after last_idx
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb4 (
    input  logic [3:0] eligible,
    input  logic [1:0] last_idx,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);

    logic [1:0] w_cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_idx;
        w_cand      = last_idx;
        for (int k = 1; k <= 4; k++) begin
            w_cand = last_idx + 2'(k);
            if (!grant_valid && eligible[w_cand]) begin
                grant_valid = 1'b1;
                grant_idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ac_drain_sched.sv
// ----------------------------------------------------------------------------
// ac_drain_sched : drains finished accumulator results into a one-entry output
//                  register, round-robin across four requesters, per frame.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ac_drain_sched
    import smac_ctrl_pkg::*;
#(
    parameter int M   = 16,
    parameter int PA  = 8,
    parameter int PW  = 4,
    parameter int MNO = 288,
    parameter int DW  = dw_calc(M, PA, PW, MNO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_results,
    input  logic [N_REQ-1:0] req,
    input  logic [DW-1:0]    acc_in0,
    input  logic [DW-1:0]    acc_in1,
    input  logic [DW-1:0]    acc_in2,
    input  logic [DW-1:0]    acc_in3,
    input  logic             out_ready,
    output logic [1:0]       sel_w_en,
    output logic [N_REQ-1:0] ack,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [1:0]       r_last_idx;
    logic [1:0]       r_sel;
    logic [N_REQ-1:0] r_ack;
    logic             r_out_valid;
    logic [DW-1:0]    r_out_data;
    logic             r_busy;
    logic             r_done;

    logic [DW-1:0]    w_acc [N_REQ];
    logic             w_xfer;
    logic             w_free;
    logic [N_REQ-1:0] w_eligible;
    logic             w_gv;
    logic [1:0]       w_gidx;
    logic             w_grant;

    assign w_acc[0] = acc_in0;
    assign w_acc[1] = acc_in1;
    assign w_acc[2] = acc_in2;
    assign w_acc[3] = acc_in3;

    assign w_xfer     = r_out_valid & out_ready;
    assign w_free     = ~r_out_valid | w_xfer;
    // A requester acked this cycle still shows req high; mask it to avoid a double grant.
    assign w_eligible = req & ~r_ack;
    assign w_grant    = (r_state == RUN) && w_free && w_gv;

    rr_arb4 u_arb (
        .eligible    (w_eligible),
        .last_idx    (r_last_idx),
        .grant_valid (w_gv),
        .grant_idx   (w_gidx)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start && (n_results != '0)) w_state_nxt = RUN;
            RUN:     if (w_grant && (r_remaining == CNT_W'(1))) w_state_nxt = FLUSH;
            FLUSH:   if (w_xfer) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_last_idx  <= 2'd3;
            r_sel       <= '0;
            r_ack       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    if (start) begin
                        if (n_results != '0) begin
                            r_remaining <= n_results;
                            r_busy      <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_grant) begin
                        r_out_data  <= w_acc[w_gidx];
                        r_sel       <= w_gidx;
                        r_out_valid <= 1'b1;
                        r_ack       <= N_REQ'(1) << w_gidx;
                        r_last_idx  <= w_gidx;
                        r_remaining <= r_remaining - CNT_W'(1);
                    end else begin
                        if (w_xfer) r_out_valid <= 1'b0;
                        r_ack <= '0;
                    end
                end
                FLUSH: begin
                    r_ack <= '0;
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                DONE: begin
                    r_ack  <= '0;
                    r_busy <= 1'b0;
                end
                default: r_ack <= '0;
            endcase
        end
    end

    assign sel_w_en  = r_sel;
    assign ack       = r_ack;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ac_drain_sched.sv
// ----------------------------------------------------------------------------
// tb_ac_drain_sched : directed vector table plus reset-recovery sequence
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ac_drain_sched;

    localparam int DW = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    n_results;
    logic [3:0]    req;
    logic [DW-1:0] acc_in0, acc_in1, acc_in2, acc_in3;
    logic          out_ready;
    logic [1:0]    sel_w_en;
    logic [3:0]    ack;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] accv [4];
    int            n_chk  = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    ac_drain_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_results (n_results),
        .req       (req),
        .acc_in0   (acc_in0),
        .acc_in1   (acc_in1),
        .acc_in2   (acc_in2),
        .acc_in3   (acc_in3),
        .out_ready (out_ready),
        .sel_w_en  (sel_w_en),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic       st;
        logic [7:0] n;
        logic [3:0] rq;
        logic       rdy;
        logic [1:0] sel;
        logic [3:0] ack;
        logic       val;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, input logic [7:0] n, input logic [3:0] rq, input logic rdy,
                       input logic [1:0] s, input logic [3:0] a, input logic v, input logic b,
                       input logic d);
        vec_t t;
        t.st = st; t.n = n; t.rq = rq; t.rdy = rdy;
        t.sel = s; t.ack = a; t.val = v; t.busy = b; t.done = d;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        accv[0] = 26'h1111110;
        accv[1] = 26'h2222221;
        accv[2] = 26'h3333332;
        accv[3] = 26'h0444443;
        acc_in0 = accv[0]; acc_in1 = accv[1]; acc_in2 = accv[2]; acc_in3 = accv[3];
        rst = 1'b1; start = 1'b0; n_results = '0; req = '0; out_ready = 1'b0;

        // frame of 4 with all requesters; start during DONE must be ignored
        add(1, 4, 4'hF, 1,  0, 4'h0, 0, 1, 0);
        add(0, 0, 4'hF, 1,  0, 4'h1, 1, 1, 0);
        add(0, 0, 4'hF, 1,  1, 4'h2, 1, 1, 0);
        add(0, 0, 4'hF, 1,  2, 4'h4, 1, 1, 0);
        add(0, 0, 4'hF, 1,  3, 4'h8, 1, 1, 0);
        add(0, 0, 4'hF, 1,  3, 4'h0, 0, 1, 1);
        add(1, 2, 4'hF, 1,  3, 4'h0, 0, 0, 0);
        add(0, 0, 4'hF, 1,  3, 4'h0, 0, 0, 0);
        // zero-length frame
        add(1, 0, 4'hF, 1,  3, 4'h0, 0, 0, 1);
        add(0, 0, 4'hF, 1,  3, 4'h0, 0, 0, 0);
        // single requester: ack masking gives alternate-cycle grants
        add(1, 2, 4'h2, 1,  3, 4'h0, 0, 1, 0);
        add(0, 0, 4'h2, 1,  1, 4'h2, 1, 1, 0);
        add(0, 0, 4'h2, 1,  1, 4'h0, 0, 1, 0);
        add(0, 0, 4'h2, 1,  1, 4'h2, 1, 1, 0);
        add(0, 0, 4'h2, 1,  1, 4'h0, 0, 1, 1);
        add(0, 0, 4'h2, 1,  1, 4'h0, 0, 0, 0);
        // start during RUN with another count is ignored
        add(1, 2, 4'hF, 1,  1, 4'h0, 0, 1, 0);
        add(1, 5, 4'hF, 1,  2, 4'h4, 1, 1, 0);
        add(1, 7, 4'hF, 1,  3, 4'h8, 1, 1, 0);
        add(0, 0, 4'hF, 1,  3, 4'h0, 0, 1, 1);
        add(0, 0, 4'hF, 1,  3, 4'h0, 0, 0, 0);
        // backpressure hold for 5 cycles
        add(1, 3, 4'h4, 0,  3, 4'h0, 0, 1, 0);
        add(0, 0, 4'h4, 0,  2, 4'h4, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 4'h4, 0,  2, 4'h0, 1, 1, 0);
        add(0, 0, 4'h4, 1,  2, 4'h4, 1, 1, 0);
        add(0, 0, 4'h4, 1,  2, 4'h0, 0, 1, 0);
        add(0, 0, 4'h4, 1,  2, 4'h4, 1, 1, 0);
        add(0, 0, 4'h4, 1,  2, 4'h0, 0, 1, 1);
        add(0, 0, 4'h4, 0,  2, 4'h0, 0, 0, 0);

        step();
        step();
        chk("reset sel", 32'(sel_w_en), 32'd0);
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset data", 32'(out_data), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst = 1'b0;

        for (int r = 0; r < vq.size(); r++) begin
            start = vq[r].st; n_results = vq[r].n; req = vq[r].rq; out_ready = vq[r].rdy;
            step();
            chk($sformatf("row%0d sel", r),   32'(sel_w_en),  32'(vq[r].sel));
            chk($sformatf("row%0d ack", r),   32'(ack),       32'(vq[r].ack));
            chk($sformatf("row%0d valid", r), 32'(out_valid), 32'(vq[r].val));
            chk($sformatf("row%0d busy", r),  32'(busy),      32'(vq[r].busy));
            chk($sformatf("row%0d done", r),  32'(done),      32'(vq[r].done));
            if (vq[r].val)
                chk($sformatf("row%0d data", r), 32'(out_data), 32'(accv[vq[r].sel]));
        end

        // reset mid-frame with a pending result, then a normal frame
        start = 1'b1; n_results = 8'd3; req = 4'hF; out_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("mid valid before rst", 32'(out_valid), 32'd1);
        chk("mid sel before rst", 32'(sel_w_en), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid rst sel", 32'(sel_w_en), 32'd0);
        chk("mid rst ack", 32'(ack), 32'd0);
        chk("mid rst valid", 32'(out_valid), 32'd0);
        chk("mid rst data", 32'(out_data), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        step();
        chk("post rst done", 32'(done), 32'd0);
        chk("post rst busy", 32'(busy), 32'd0);
        start = 1'b1; n_results = 8'd1; out_ready = 1'b1;
        step();
        start = 1'b0;
        chk("restart busy", 32'(busy), 32'd1);
        step();
        chk("restart sel", 32'(sel_w_en), 32'd0);
        chk("restart ack", 32'(ack), 32'd1);
        chk("restart data", 32'(out_data), 32'(accv[0]));
        step();
        chk("restart done", 32'(done), 32'd1);
        chk("restart valid", 32'(out_valid), 32'd0);
        step();
        chk("restart idle busy", 32'(busy), 32'd0);
        chk("restart idle done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
